// File: rtl/avalon_master.sv
// Avalon-MM master engine: turns single or incrementing burst commands into
// waitrequest-compliant transfers, with a stall timeout that aborts hung slaves.
module avalon_master #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned TIMEOUT      = 256
) (
    input  logic                  iClk,
    input  logic                  iReset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_address,
    input  logic [3:0]            cmd_byteenable,
    input  logic [4:0]            cmd_length,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] avm_address,
    output logic [3:0]            avm_byteenable,
    output logic                  avm_read,
    output logic                  avm_write,
    output logic [DATA_WIDTH-1:0] avm_writedata,
    input  logic [DATA_WIDTH-1:0] avm_readdata,
    input  logic                  avm_waitrequest
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_FETCH,
        S_WR_BUS,
        S_RD_BUS,
        S_RD_LAT
    } state_t;

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] avm_address_q, avm_address_d;
    logic [3:0]            avm_byteenable_q, avm_byteenable_d;
    logic                  avm_read_q, avm_read_d;
    logic                  avm_write_q, avm_write_d;
    logic [DATA_WIDTH-1:0] avm_writedata_q, avm_writedata_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic [4:0]            beats_q, beats_d;
    logic [TW-1:0]         timer_q, timer_d;

    logic [4:0]            norm_len;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic [TW-1:0]         timer_inc;
    logic                  timeout_hit;
    logic                  last_beat;

    assign cmd_ready = (state_q == S_IDLE) && !iReset;
    assign wr_ready  = (state_q == S_WR_FETCH);

    assign norm_len    = (cmd_length == 5'd0) ? 5'd1 :
                         (cmd_length > 5'd16) ? 5'd16 : cmd_length;
    assign addr_next   = avm_address_q + ADDR_WIDTH'(4);
    assign last_beat   = (beats_q == 5'd1);
    assign timer_inc   = timer_q + TW'(1);
    // Only evaluated while stalled in a bus state, so it marks the TIMEOUT-th stall cycle.
    assign timeout_hit = (TIMEOUT != 0) && (timer_inc == TW'(TIMEOUT));

    always_comb begin
        state_d          = state_q;
        avm_address_d    = avm_address_q;
        avm_byteenable_d = avm_byteenable_q;
        avm_read_d       = avm_read_q;
        avm_write_d      = avm_write_q;
        avm_writedata_d  = avm_writedata_q;
        rd_data_d        = rd_data_q;
        rd_valid_d       = 1'b0;
        done_d           = 1'b0;
        error_d          = 1'b0;
        beats_d          = beats_q;
        timer_d          = '0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    avm_address_d    = cmd_address & ~ADDR_WIDTH'(3);
                    avm_byteenable_d = cmd_byteenable;
                    beats_d          = norm_len;
                    if (cmd_write) begin
                        state_d = S_WR_FETCH;
                    end else begin
                        state_d    = S_RD_BUS;
                        avm_read_d = 1'b1;
                    end
                end
            end

            S_WR_FETCH: begin
                if (wr_valid) begin
                    avm_writedata_d = wr_data;
                    avm_write_d     = 1'b1;
                    state_d         = S_WR_BUS;
                end
            end

            S_WR_BUS: begin
                if (!avm_waitrequest) begin
                    avm_write_d   = 1'b0;
                    avm_address_d = addr_next;
                    beats_d       = beats_q - 5'd1;
                    if (last_beat) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_WR_FETCH;
                    end
                end else if (timeout_hit) begin
                    avm_write_d = 1'b0;
                    state_d     = S_IDLE;
                    done_d      = 1'b1;
                    error_d     = 1'b1;
                end else begin
                    timer_d = timer_inc;
                end
            end

            S_RD_BUS: begin
                if (!avm_waitrequest) begin
                    if (READ_LATENCY == 0) begin
                        rd_data_d     = avm_readdata;
                        rd_valid_d    = 1'b1;
                        avm_address_d = addr_next;
                        beats_d       = beats_q - 5'd1;
                        if (last_beat) begin
                            avm_read_d = 1'b0;
                            state_d    = S_IDLE;
                            done_d     = 1'b1;
                        end
                    end else begin
                        avm_read_d = 1'b0;
                        state_d    = S_RD_LAT;
                    end
                end else if (timeout_hit) begin
                    avm_read_d = 1'b0;
                    state_d    = S_IDLE;
                    done_d     = 1'b1;
                    error_d    = 1'b1;
                end else begin
                    timer_d = timer_inc;
                end
            end

            S_RD_LAT: begin
                rd_data_d     = avm_readdata;
                rd_valid_d    = 1'b1;
                avm_address_d = addr_next;
                beats_d       = beats_q - 5'd1;
                if (last_beat) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d    = S_RD_BUS;
                    avm_read_d = 1'b1;
                end
            end

            default: begin
                state_d     = S_IDLE;
                avm_read_d  = 1'b0;
                avm_write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            state_q          <= S_IDLE;
            avm_address_q    <= '0;
            avm_byteenable_q <= '0;
            avm_read_q       <= 1'b0;
            avm_write_q      <= 1'b0;
            avm_writedata_q  <= '0;
            rd_data_q        <= '0;
            rd_valid_q       <= 1'b0;
            done_q           <= 1'b0;
            error_q          <= 1'b0;
            beats_q          <= '0;
            timer_q          <= '0;
        end else begin
            state_q          <= state_d;
            avm_address_q    <= avm_address_d;
            avm_byteenable_q <= avm_byteenable_d;
            avm_read_q       <= avm_read_d;
            avm_write_q      <= avm_write_d;
            avm_writedata_q  <= avm_writedata_d;
            rd_data_q        <= rd_data_d;
            rd_valid_q       <= rd_valid_d;
            done_q           <= done_d;
            error_q          <= error_d;
            beats_q          <= beats_d;
            timer_q          <= timer_d;
        end
    end

    assign avm_address    = avm_address_q;
    assign avm_byteenable = avm_byteenable_q;
    assign avm_read       = avm_read_q;
    assign avm_write      = avm_write_q;
    assign avm_writedata  = avm_writedata_q;
    assign rd_data        = rd_data_q;
    assign rd_valid       = rd_valid_q;
    assign done           = done_q;
    assign error          = error_q;

endmodule

// File: tb/tb_avalon_master.sv
// Directed bench for avalon_master: a small stalling slave model plus
// per-scenario tasks with hand-computed expectations.
module tb_avalon_master;

    logic        iClk = 1'b0;
    logic        iReset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_address;
    logic [3:0]  cmd_byteenable;
    logic [4:0]  cmd_length;
    logic [31:0] wr_data;
    logic        wr_valid, wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid, done, error;
    logic [31:0] avm_address;
    logic [3:0]  avm_byteenable;
    logic        avm_read, avm_write;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata = '0;
    logic        avm_waitrequest;

    int          checks = 0;
    int          failures = 0;

    int          stall_cfg = 0;
    logic        stuck = 1'b0;
    logic        cur_is_write = 1'b0;
    int          wait_cnt = 0;
    int          wr_taken = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          both_cnt = 0;
    int          bad_rdv = 0;
    int          stab_cnt = 0;
    logic        prev_stall = 1'b0;
    logic        prev_rst = 1'b0;
    logic        prev_rd = 1'b0;
    logic        prev_wr = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] prev_wdata = '0;
    logic [3:0]  prev_be = '0;

    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    logic [3:0]  wb_q[$];
    logic [31:0] ra_q[$];
    logic [31:0] rd_q[$];

    always #5 iClk = ~iClk;

    avalon_master #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .READ_LATENCY(1),
        .TIMEOUT     (8)
    ) dut (
        .iClk           (iClk),
        .iReset         (iReset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_write      (cmd_write),
        .cmd_address    (cmd_address),
        .cmd_byteenable (cmd_byteenable),
        .cmd_length     (cmd_length),
        .wr_data        (wr_data),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .done           (done),
        .error          (error),
        .avm_address    (avm_address),
        .avm_byteenable (avm_byteenable),
        .avm_read       (avm_read),
        .avm_write      (avm_write),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (avm_readdata),
        .avm_waitrequest(avm_waitrequest)
    );

    // Slave stalls each transfer for stall_cfg cycles; readdata is the address, one cycle later.
    assign avm_waitrequest = stuck || ((avm_read || avm_write) && (wait_cnt < stall_cfg));

    always @(posedge iClk) begin
        if ((avm_read || avm_write) && avm_waitrequest) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
        if (avm_read && !avm_waitrequest) begin
            avm_readdata <= avm_address;
            ra_q.push_back(avm_address);
        end
        if (avm_write && !avm_waitrequest) begin
            wa_q.push_back(avm_address);
            wd_q.push_back(avm_writedata);
            wb_q.push_back(avm_byteenable);
        end
        if (wr_ready && wr_valid) wr_taken <= wr_taken + 1;
        if (rd_valid) begin
            rd_q.push_back(rd_data);
            if (cur_is_write) bad_rdv <= bad_rdv + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
        if (error) err_cnt <= err_cnt + 1;
        if (avm_read && avm_write) both_cnt <= both_cnt + 1;
        if (prev_stall && !prev_rst && !done) begin
            if (avm_read !== prev_rd || avm_write !== prev_wr || avm_address !== prev_addr ||
                avm_byteenable !== prev_be || (prev_wr && avm_writedata !== prev_wdata))
                stab_cnt <= stab_cnt + 1;
        end
        prev_stall <= (avm_read || avm_write) && avm_waitrequest;
        prev_rst   <= iReset;
        prev_rd    <= avm_read;
        prev_wr    <= avm_write;
        prev_addr  <= avm_address;
        prev_wdata <= avm_writedata;
        prev_be    <= avm_byteenable;
    end

    task automatic tick;
        @(posedge iClk);
        #1;
    endtask

    // Issues one command and returns the cycle (1 = first cycle after acceptance) in which done is seen.
    task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [4:0] len,
                           input logic [3:0] be, output int n);
        int base;
        base           = wr_taken;
        cur_is_write   = wr;
        cmd_write      = wr;
        cmd_address    = addr;
        cmd_length     = len;
        cmd_byteenable = be;
        cmd_valid      = 1'b1;
        wr_valid       = wr;
        wr_data        = 32'hD000_0000;
        tick;
        cmd_valid = 1'b0;
        n = 1;
        while (done !== 1'b1 && n < 200) begin
            wr_data = 32'hD000_0000 + 32'(wr_taken - base);
            tick;
            n++;
        end
        wr_valid = 1'b0;
        tick;
    endtask

    task automatic test_reset;
        iReset = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = '0; cmd_byteenable = '0;
        cmd_length = '0; wr_data = '0; wr_valid = 1'b0;
        tick; tick; tick;
        checks++;
        if ({cmd_ready, wr_ready, avm_read, avm_write, rd_valid, done, error} !== 7'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=0000000",
                     {cmd_ready, wr_ready, avm_read, avm_write, rd_valid, done, error});
        end
        checks++;
        if (avm_address !== 32'h0 || avm_writedata !== 32'h0 || rd_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_data got=%h/%h/%h exp=0", avm_address, avm_writedata, rd_data);
        end
        iReset = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready got=%b exp=1", cmd_ready);
        end
        tick;
    endtask

    task automatic test_single_write;
        int w0;
        w0 = wa_q.size();
        cur_is_write = 1'b1;
        cmd_write = 1'b1; cmd_address = 32'h10; cmd_byteenable = 4'hF; cmd_length = 5'd1;
        wr_valid = 1'b1; wr_data = 32'hA5A5_0001;
        cmd_valid = 1'b1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL sw_cmd_ready got=%b exp=1", cmd_ready);
        end
        tick;
        cmd_valid = 1'b0;
        checks++;
        if (wr_ready !== 1'b1 || avm_write !== 1'b0 || cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL sw_fetch got=wr_ready:%b avm_write:%b cmd_ready:%b exp=1/0/0",
                     wr_ready, avm_write, cmd_ready);
        end
        tick;
        wr_valid = 1'b0;
        checks++;
        if (avm_write !== 1'b1 || avm_address !== 32'h10 || avm_writedata !== 32'hA5A5_0001 ||
            avm_byteenable !== 4'hF || done !== 1'b0) begin
            failures++;
            $display("FAIL sw_bus got=%b %h %h %h done=%b exp=1 00000010 a5a50001 f done=0",
                     avm_write, avm_address, avm_writedata, avm_byteenable, done);
        end
        tick;
        checks++;
        if (done !== 1'b1 || error !== 1'b0 || avm_write !== 1'b0) begin
            failures++;
            $display("FAIL sw_done got=done:%b error:%b avm_write:%b exp=1/0/0", done, error, avm_write);
        end
        tick;
        checks++;
        if (done !== 1'b0 || wa_q.size() != w0 + 1 || wa_q[w0] !== 32'h10 || wd_q[w0] !== 32'hA5A5_0001) begin
            failures++;
            $display("FAIL sw_log got=done:%b beats:%0d exp=done:0 beats:1", done, wa_q.size() - w0);
        end
    endtask

    task automatic test_burst_read;
        int r0, a0, n;
        logic [31:0] exp_a;
        r0 = rd_q.size(); a0 = ra_q.size();
        stall_cfg = 2;
        cur_is_write = 1'b0;
        cmd_write = 1'b0; cmd_address = 32'h100; cmd_byteenable = 4'hF; cmd_length = 5'd4;
        cmd_valid = 1'b1;
        tick;
        cmd_valid = 1'b0;
        n = 1;
        checks++;
        if (avm_read !== 1'b1 || avm_address !== 32'h100) begin
            failures++;
            $display("FAIL br_first got=%b %h exp=1 00000100", avm_read, avm_address);
        end
        while (done !== 1'b1 && n < 100) begin
            tick;
            n++;
        end
        checks++;
        if (n != 17) begin
            failures++;
            $display("FAIL br_done_cycle got=%0d exp=17", n);
        end
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 32'h10C || error !== 1'b0) begin
            failures++;
            $display("FAIL br_last_with_done got=rv:%b %h err:%b exp=rv:1 0000010c err:0",
                     rd_valid, rd_data, error);
        end
        tick;
        stall_cfg = 0;
        checks++;
        if (rd_q.size() != r0 + 4 || ra_q.size() != a0 + 4) begin
            failures++;
            $display("FAIL br_count got=%0d/%0d exp=4/4", rd_q.size() - r0, ra_q.size() - a0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                exp_a = 32'h100 + 32'(4 * i);
                checks++;
                if (rd_q[r0 + i] !== exp_a || ra_q[a0 + i] !== exp_a) begin
                    failures++;
                    $display("FAIL br_beat%0d got=rd:%h addr:%h exp=%h", i, rd_q[r0 + i], ra_q[a0 + i], exp_a);
                end
            end
        end
    endtask

    task automatic test_write_gap;
        int w0, gap_bad;
        w0 = wa_q.size();
        gap_bad = 0;
        cur_is_write = 1'b1;
        cmd_write = 1'b1; cmd_address = 32'h200; cmd_byteenable = 4'hF; cmd_length = 5'd2;
        wr_valid = 1'b1; wr_data = 32'h1111_0000;
        cmd_valid = 1'b1;
        tick;
        cmd_valid = 1'b0;
        tick;
        wr_valid = 1'b0;
        checks++;
        if (avm_write !== 1'b1 || avm_address !== 32'h200) begin
            failures++;
            $display("FAIL wg_beat0 got=%b %h exp=1 00000200", avm_write, avm_address);
        end
        tick;
        for (int i = 0; i < 5; i++) begin
            if (avm_write !== 1'b0 || wr_ready !== 1'b1) gap_bad++;
            tick;
        end
        checks++;
        if (gap_bad != 0) begin
            failures++;
            $display("FAIL wg_gap got=%0d bad cycles exp=0", gap_bad);
        end
        wr_valid = 1'b1; wr_data = 32'h2222_0001;
        tick;
        wr_valid = 1'b0;
        checks++;
        if (avm_write !== 1'b1 || avm_address !== 32'h204 || avm_writedata !== 32'h2222_0001 || done !== 1'b0) begin
            failures++;
            $display("FAIL wg_beat1 got=%b %h %h done=%b exp=1 00000204 22220001 done=0",
                     avm_write, avm_address, avm_writedata, done);
        end
        tick;
        checks++;
        if (done !== 1'b1 || error !== 1'b0) begin
            failures++;
            $display("FAIL wg_done got=%b/%b exp=1/0", done, error);
        end
        tick;
        checks++;
        if (wa_q.size() != w0 + 2 || wd_q[w0] !== 32'h1111_0000 || wd_q[w0 + 1] !== 32'h2222_0001 ||
            wa_q[w0 + 1] !== 32'h204) begin
            failures++;
            $display("FAIL wg_log got=beats:%0d exp=2", wa_q.size() - w0);
        end
    endtask

    task automatic test_timeout;
        int r0, n, rd_high;
        r0 = rd_q.size();
        stuck = 1'b1;
        cur_is_write = 1'b0;
        cmd_write = 1'b0; cmd_address = 32'h300; cmd_byteenable = 4'hF; cmd_length = 5'd1;
        cmd_valid = 1'b1;
        tick;
        cmd_valid = 1'b0;
        n = 1; rd_high = 0;
        while (done !== 1'b1 && n < 40) begin
            if (avm_read === 1'b1) rd_high++;
            tick;
            n++;
        end
        checks++;
        if (rd_high != 8 || n != 9) begin
            failures++;
            $display("FAIL to_read_cycles got=high:%0d done_at:%0d exp=high:8 done_at:9", rd_high, n);
        end
        checks++;
        if (error !== 1'b1 || avm_read !== 1'b0 || rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL to_abort got=err:%b rd:%b rv:%b exp=1/0/0", error, avm_read, rd_valid);
        end
        stuck = 1'b0;
        tick;
        checks++;
        if (cmd_ready !== 1'b1 || done !== 1'b0 || error !== 1'b0 || rd_q.size() != r0) begin
            failures++;
            $display("FAIL to_after got=ready:%b done:%b err:%b rv:%0d exp=1/0/0/0",
                     cmd_ready, done, error, rd_q.size() - r0);
        end
    endtask

    task automatic test_wrap_length;
        int w0, r0, n;
        w0 = wa_q.size();
        run_cmd(1'b1, 32'hFFFF_FFFE, 5'd0, 4'h3, n);
        checks++;
        if (n != 3 || wa_q.size() != w0 + 1 || wa_q[w0] !== 32'hFFFF_FFFC || wb_q[w0] !== 4'h3) begin
            failures++;
            $display("FAIL wl_len0 got=n:%0d beats:%0d exp=n:3 beats:1 at fffffffc be 3", n, wa_q.size() - w0);
        end
        r0 = rd_q.size();
        run_cmd(1'b0, 32'hFFFF_FFFC, 5'd2, 4'hF, n);
        checks++;
        if (n != 5 || rd_q.size() != r0 + 2) begin
            failures++;
            $display("FAIL wl_wrap_count got=n:%0d beats:%0d exp=n:5 beats:2", n, rd_q.size() - r0);
        end else begin
            checks++;
            if (rd_q[r0] !== 32'hFFFF_FFFC || rd_q[r0 + 1] !== 32'h0) begin
                failures++;
                $display("FAIL wl_wrap_addr got=%h,%h exp=fffffffc,00000000", rd_q[r0], rd_q[r0 + 1]);
            end
        end
        w0 = wa_q.size();
        run_cmd(1'b1, 32'h400, 5'd31, 4'hF, n);
        checks++;
        if (n != 33 || wa_q.size() != w0 + 16) begin
            failures++;
            $display("FAIL wl_sat16 got=n:%0d beats:%0d exp=n:33 beats:16", n, wa_q.size() - w0);
        end else begin
            checks++;
            if (wa_q[w0 + 15] !== 32'h43C || wd_q[w0 + 15] !== 32'hD000_000F) begin
                failures++;
                $display("FAIL wl_sat16_last got=%h %h exp=0000043c d000000f", wa_q[w0 + 15], wd_q[w0 + 15]);
            end
        end
    endtask

    task automatic test_reset_mid;
        int w0, n, dc, ec;
        w0 = wa_q.size();
        cur_is_write = 1'b1;
        cmd_write = 1'b1; cmd_address = 32'h500; cmd_byteenable = 4'hF; cmd_length = 5'd8;
        wr_valid = 1'b1; wr_data = 32'h3333_0000;
        cmd_valid = 1'b1;
        tick;
        cmd_valid = 1'b0;
        n = 1;
        while (!(wa_q.size() == w0 + 2 && avm_write === 1'b1) && n < 100) begin
            tick;
            n++;
        end
        checks++;
        if (n != 6 || avm_address !== 32'h508) begin
            failures++;
            $display("FAIL rm_third_beat got=cycle:%0d addr:%h exp=cycle:6 addr:00000508", n, avm_address);
        end
        dc = done_cnt; ec = err_cnt;
        iReset = 1'b1;
        tick;
        checks++;
        if (avm_write !== 1'b0 || cmd_ready !== 1'b0 || wr_ready !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL rm_drop got=wr:%b ready:%b wr_ready:%b done:%b exp=0/0/0/0",
                     avm_write, cmd_ready, wr_ready, done);
        end
        iReset = 1'b0;
        wr_valid = 1'b0;
        tick; tick;
        checks++;
        if (done_cnt != dc || err_cnt != ec || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL rm_no_done got=done+%0d err+%0d ready:%b exp=+0 +0 1",
                     done_cnt - dc, err_cnt - ec, cmd_ready);
        end
        w0 = wa_q.size();
        run_cmd(1'b1, 32'h600, 5'd1, 4'hF, n);
        checks++;
        if (n != 3 || wa_q.size() != w0 + 1 || wa_q[w0] !== 32'h600) begin
            failures++;
            $display("FAIL rm_recover got=n:%0d beats:%0d exp=n:3 beats:1", n, wa_q.size() - w0);
        end
    endtask

    task automatic test_invariants;
        checks++;
        if (both_cnt != 0 || bad_rdv != 0 || stab_cnt != 0) begin
            failures++;
            $display("FAIL invariants got=both:%0d rdv_in_write:%0d unstable:%0d exp=0/0/0",
                     both_cnt, bad_rdv, stab_cnt);
        end
    endtask

    initial begin
        test_reset;
        test_single_write;
        test_burst_read;
        test_write_gap;
        test_timeout;
        test_wrap_length;
        test_reset_mid;
        test_invariants;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/avalon_master.md
Name: avalon_master

Overview:
- Avalon-MM master engine. Turns a simple local command (single or incrementing multi-word read/write) into Avalon-MM transfers that obey waitrequest.
- Sits between local control logic and any Avalon-MM slave, including our own register-bank slaves.
- Provides a write-data stream in, a read-data stream out, done/error pulses, and a waitrequest timeout so that a hung slave cannot lock the master.

Parameters:
- ADDR_WIDTH, 32: width of cmd_address and avm_address.
- DATA_WIDTH, 32: data width. Fixed at 32; byteenable is 4 bits.
- READ_LATENCY, 1: cycles from read acceptance (avm_read=1, avm_waitrequest=0) to valid avm_readdata. Legal values are 0 and 1.
- TIMEOUT, 256: number of consecutive waitrequest-high cycles that abort a command. 0 disables the timeout.

Ports:
- iClk  in  1  clock; all logic is on the rising edge.
- iReset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  engine idle; a command is accepted when cmd_valid and cmd_ready are both high.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_address  in  ADDR_WIDTH  start byte address; bits [1:0] are ignored (forced to 0).
- cmd_byteenable  in  4  byteenable applied to every beat.
- cmd_length  in  5  beat count, 1..16; 0 is treated as 1; values above 16 saturate to 16.
- wr_data  in  32  write beat data.
- wr_valid  in  1  write beat available.
- wr_ready  out  1  engine takes wr_data this cycle.
- rd_data  out  32  read beat data.
- rd_valid  out  1  one-cycle qualifier for rd_data.
- done  out  1  one-cycle pulse when a command completes or aborts.
- error  out  1  one-cycle pulse, coincident with done, on timeout abort.
- avm_address  out  ADDR_WIDTH  Avalon address.
- avm_byteenable  out  4  Avalon byteenable.
- avm_read  out  1  Avalon read.
- avm_write  out  1  Avalon write.
- avm_writedata  out  32  Avalon write data.
- avm_readdata  in  32  Avalon read data.
- avm_waitrequest  in  1  Avalon stall.

Behaviour:
- Reset: iReset high at an edge sets state=IDLE and clears all outputs to 0 (cmd_ready included while iReset is high). Beat counter and timeout counter are cleared. No done or error pulse is produced.
  - Reset mid-command: avm_read and avm_write drop on that edge, and the command is discarded.
- States: IDLE, WR_FETCH, WR_BUS, RD_BUS, RD_LAT.
- All outputs are registered except cmd_ready and wr_ready:
  - cmd_ready = (state==IDLE) and not iReset.
  - wr_ready = (state==WR_FETCH).
- IDLE: on accept, latch address (with [1:0]=0), byteenable and the normalized length.
  - Write command -> WR_FETCH.
  - Read command -> RD_BUS, with avm_read=1 from the next cycle.
- WR_FETCH: wait for wr_valid. On the wr_valid cycle, latch avm_writedata, set avm_write=1, go to WR_BUS. Each write beat therefore costs one bubble cycle.
- WR_BUS: hold avm_address, avm_byteenable, avm_writedata and avm_write stable while avm_waitrequest=1.
  - On the cycle with avm_waitrequest=0 the beat is accepted: avm_write goes to 0 on the next edge and the address advances by 4.
  - If beats remain -> WR_FETCH; otherwise -> IDLE with done=1.
- RD_BUS: hold avm_read and the address stable while waitrequest=1. On acceptance:
  - READ_LATENCY=0: capture avm_readdata in the same cycle; rd_valid=1 on the next cycle.
  - READ_LATENCY=1: drop avm_read and go to RD_LAT; capture avm_readdata in RD_LAT; rd_valid=1 on the following cycle.
  - After the beat, the address advances by 4. If beats remain, reassert avm_read (RD_BUS); otherwise go to IDLE and pulse done in the same cycle as the last rd_valid.
- The master never deasserts avm_read or avm_write while waitrequest=1, except on timeout or reset.
- Address arithmetic: increment by 4 modulo 2^ADDR_WIDTH; wrap to 0 silently.
- Timeout counter:
  - Counts cycles in WR_BUS or RD_BUS with waitrequest=1; clears on acceptance and on every state entry.
  - When the count reaches TIMEOUT: drop avm_read/avm_write, go to IDLE, pulse done=1 and error=1.
  - Remaining beats are discarded and no rd_valid is issued for the aborted beat.
  - rd_data beats already delivered stand.
- avm_read and avm_write are never both high. rd_valid is never high in a write command.
- cmd_valid while busy is ignored (cmd_ready=0); there is no queueing.

Test Plan:
- Single write, zero-wait slave: cmd addr=0x10, be=0xF, len=1, wr_data=0xA5A5_0001 -> one avm_write cycle at 0x10 with data 0xA5A5_0001; done pulses 2 cycles after acceptance; error=0.
- 4-beat read, READ_LATENCY=1, slave waitrequest high 2 cycles per beat, readdata=address:
  - avm_read is held stable across stalls at addresses 0x100, 0x104, 0x108, 0x10C.
  - rd_data = 0x100..0x10C in order, one rd_valid each.
  - done coincides with the last rd_valid.
- Write with wr_valid gap: len=2, second wr_valid delayed 5 cycles -> avm_write stays 0 during the gap; the second beat goes to base+4; done after the second acceptance.
- Timeout: TIMEOUT=8, read with waitrequest stuck high -> avm_read high exactly 8 cycles, then 0; done=1 and error=1 in the same cycle; no rd_valid; cmd_ready=1 on the next cycle.
- Wrap and length edge: addr=0xFFFF_FFFC, len=0 -> one beat at 0xFFFF_FFFC. Then addr=0xFFFF_FFFC, len=2 -> beats at 0xFFFF_FFFC and 0x0000_0000. cmd_length=31 -> exactly 16 beats.
- Reset mid-burst: iReset during the 3rd beat of a len=8 write -> avm_write=0 on that edge; no done or error pulse; a new command is accepted normally after release.
